// File: rtl/sel_unit_pipe.sv
// Two-stage valid/ready lane-select unit: DEMUX, priority encode, decode or zero per transaction,
// with a saturating counter of priority-encode requests that found no set bit.
module sel_unit_pipe #(
  parameter  int SEL_W = 3,
  parameter  int CNT_W = 8,
  localparam int N     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic             in_en,
  input  logic             in_d,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_hit,
  output logic [1:0]       out_mode,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_DEMUX = 2'd0,
    MODE_PENC  = 2'd1,
    MODE_DEC   = 2'd2,
    MODE_ZERO  = 2'd3
  } mode_e;

  logic             s1_v_q, s2_v_q;
  mode_e            s1_mode_q, s2_mode_q;
  logic             s1_en_q, s1_d_q;
  logic [SEL_W-1:0] s1_sel_q;
  logic [N-1:0]     s1_vec_q;
  logic [N-1:0]     s2_data_q, res_data;
  logic             s2_hit_q, res_hit;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             s1_adv, s2_adv, accept;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;

  // Result is computed from the S1 fields, so S2 only registers finished data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    res_data = '0;
    res_hit  = 1'b0;
    case (s1_mode_q)
      MODE_DEMUX: res_data[s1_sel_q] = s1_en_q & s1_d_q;
      MODE_PENC: begin
        res_hit = |s1_vec_q;
        for (int i = 0; i < N; i++) begin
          if (s1_vec_q[i]) res_data = N'(i);
        end
      end
      MODE_DEC:  res_data[s1_sel_q] = s1_en_q;
      default:   res_data = '0;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (s2_v_q && out_ready && (s2_mode_q == MODE_PENC) && !s2_hit_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_mode_q <= MODE_DEMUX;
      s1_en_q   <= 1'b0;
      s1_d_q    <= 1'b0;
      s1_sel_q  <= '0;
      s1_vec_q  <= '0;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (accept) begin
        s1_mode_q <= mode_e'(in_mode);
        s1_en_q   <= in_en;
        s1_d_q    <= in_d;
        s1_sel_q  <= in_sel;
        s1_vec_q  <= in_vec;
      end
    end
  end

  // Result fields only change when a new transaction moves in, so a stalled output stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_hit_q  <= 1'b0;
      s2_mode_q <= MODE_DEMUX;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_data_q <= res_data;
        s2_hit_q  <= res_hit;
        s2_mode_q <= s1_mode_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_hit   = s2_hit_q;
  assign out_mode  = s2_mode_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sel_unit_pipe.sv
// Scoreboard bench for sel_unit_pipe (SEL_W=3, CNT_W=2): directed vectors push hand-computed
// results; an independent monitor pops and compares on every output handshake.
module tb_sel_unit_pipe;
  localparam int SEL_W = 3;
  localparam int CNT_W = 2;
  localparam int N     = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [1:0]       in_mode;
  logic             in_en, in_d;
  logic [SEL_W-1:0] in_sel;
  logic [N-1:0]     in_vec;
  logic             out_valid, out_ready;
  logic [N-1:0]     out_data;
  logic             out_hit;
  logic [1:0]       out_mode;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt;

  typedef struct {
    logic [N-1:0] data;
    logic         hit;
    logic [1:0]   mode;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  int   exp_cnt = 0;

  sel_unit_pipe #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_en(in_en),
    .in_d(in_d), .in_sel(in_sel), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_hit(out_hit), .out_mode(out_mode),
    .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every handshake against the queue and tracks the expected counter.
  always @(negedge clk) begin
    exp_t e;
    bit   miss;
    if (!rst_n) begin
      exp_cnt = 0;
    end else begin
      check("err_cnt_track", 32'(err_cnt), 32'(exp_cnt));
      miss = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got data=%0h with no result outstanding", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_hit", 32'(out_hit), 32'(e.hit));
          check("out_mode", 32'(out_mode), 32'(e.mode));
          last_pop_cyc = cyc;
          miss = (e.mode == 2'd1) && !e.hit;
        end
      end
      if (clr_cnt) exp_cnt = 0;
      else if (miss && exp_cnt != 3) exp_cnt++;
    end
  end

  task automatic issue(input logic [1:0] m, input logic en, input logic d,
                       input logic [SEL_W-1:0] sel, input logic [N-1:0] vec,
                       input logic [N-1:0] ed, input logic eh, output int acc);
    bit ok = 1'b0;
    acc      = -1;
    in_valid = 1'b1;
    in_mode  = m;
    in_en    = en;
    in_d     = d;
    in_sel   = sel;
    in_vec   = vec;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok  = 1'b1;
        acc = cyc;
        sb.push_back('{data: ed, hit: eh, mode: m});
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles, required 1");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a, a1, a2;
    rst_n = 1'b0; in_valid = 1'b0; in_mode = '0; in_en = 1'b0; in_d = 1'b0;
    in_sel = '0; in_vec = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_hit", 32'(out_hit), 0);
    check("rst_out_mode", 32'(out_mode), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // DEMUX and latency
    issue(2'd0, 1'b1, 1'b1, 3'd5, 8'h00, 8'h20, 1'b0, a);
    idle();
    drain();
    check("latency", 32'(last_pop_cyc - a), 2);

    // PENC, ZERO, DEMUX corner cases
    issue(2'd1, 1'b0, 1'b0, 3'd0, 8'b0101_0010, 8'h06, 1'b1, a);
    issue(2'd1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, a);
    issue(2'd1, 1'b0, 1'b0, 3'd0, 8'h80, 8'h07, 1'b1, a);
    issue(2'd1, 1'b0, 1'b0, 3'd0, 8'h01, 8'h00, 1'b1, a);
    issue(2'd3, 1'b1, 1'b1, 3'd4, 8'hff, 8'h00, 1'b0, a);
    issue(2'd0, 1'b1, 1'b0, 3'd6, 8'h00, 8'h00, 1'b0, a);
    issue(2'd0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 1'b0, a);
    idle();
    drain();
    check("err_cnt_after_penc", 32'(err_cnt), 1);

    // DEC back-to-back
    issue(2'd2, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0, a1);
    issue(2'd2, 1'b1, 1'b0, 3'd3, 8'h00, 8'h08, 1'b0, a2);
    idle();
    check("back_to_back_accept", 32'(a2 - a1), 1);
    drain();
    check("back_to_back_out", 32'(last_pop_cyc - a2), 2);

    // Backpressure: two fill the pipe, the third must wait
    out_ready = 1'b0;
    issue(2'd2, 1'b1, 1'b0, 3'd7, 8'h00, 8'h80, 1'b0, a);
    issue(2'd1, 1'b0, 1'b0, 3'd0, 8'b0000_1100, 8'h03, 1'b1, a);
    in_valid = 1'b1; in_mode = 2'd0; in_en = 1'b1; in_d = 1'b1; in_sel = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_out_data", 32'(out_data), 32'h80);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(2'd0, 1'b1, 1'b1, 3'd0, 8'h00, 8'h01, 1'b0, a);
    idle();
    drain();

    // Counter saturation and clear priority
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clr_cnt", 32'(err_cnt), 0);
    for (int k = 0; k < 5; k++) issue(2'd1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, a);
    idle();
    drain();
    check("err_cnt_sat", 32'(err_cnt), 3);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clr_after_sat", 32'(err_cnt), 0);
    issue(2'd1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, a);
    idle();
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clr_vs_inc_popped", 32'(sb.size()), 0);
    check("clr_vs_inc", 32'(err_cnt), 0);

    // Reset with two transactions in flight
    issue(2'd1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, a);
    idle();
    drain();
    check("pre_rst_err_cnt", 32'(err_cnt), 1);
    out_ready = 1'b0;
    issue(2'd2, 1'b1, 1'b0, 3'd1, 8'h00, 8'h02, 1'b0, a);
    issue(2'd2, 1'b1, 1'b0, 3'd2, 8'h00, 8'h04, 1'b0, a);
    idle();
    check("pre_rst_out_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale_out", 32'(out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
